// File: rtl/dfi_cmd_encoder_pkg.sv
// rtl/dfi_cmd_encoder_pkg.sv - SoftMC instruction codes/field offsets and shared types for dfi_cmd_encoder
// The SoftMC codes below stand in only when softMC.inc has not been included ahead of this file.
`ifndef DDR_INSTR
`define END_ISEQ   4'b0000
`define WAIT       4'b0100
`define DDR_INSTR  4'b1000
`define ROW_OFFSET 15
`define CS_OFFSET  18
`define WE_OFFSET  20
`define CAS_OFFSET 21
`define RAS_OFFSET 22
`endif

package dfi_cmd_encoder_pkg;

    localparam int INSTR_WIDTH = 32;

    typedef enum logic [1:0] {
        CYC_OFF,
        CYC_IDLE,
        CYC_CMD,
        CYC_CLOSE
    } cyc_kind_e;

endpackage

// File: rtl/dfi_cmd_encoder_cmd_fifo_2w.sv
// rtl/dfi_cmd_encoder_cmd_fifo_2w.sv - 2-write/1-read synchronous FIFO holding encoded instructions
module cmd_fifo_2w
    import dfi_cmd_encoder_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = INSTR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en0,
    input  logic [WIDTH-1:0]         wr_data0,
    input  logic                     wr_en1,
    input  logic [WIDTH-1:0]         wr_data1,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW-1:0]    wa0;
    logic [AW-1:0]    wa1;
    logic             pop;

    assign count    = wr_ptr - rd_ptr;
    assign rd_valid = (count != '0);
    assign pop      = rd_en & rd_valid;
    assign wa0      = wr_ptr[AW-1:0];
    // Second write lands after the first when both are used in one cycle.
    assign wa1      = wa0 + AW'(wr_en0);
    assign rd_data  = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (wr_en0) mem[wa0] <= wr_data0;
        if (wr_en1) mem[wa1] <= wr_data1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(wr_en0) + (AW+1)'(wr_en1);
            rd_ptr <= rd_ptr + (AW+1)'(pop);
        end
    end

endmodule

// File: rtl/dfi_cmd_encoder.sv
// rtl/dfi_cmd_encoder.sv - DFI command bus to SoftMC instruction stream encoder (option: DFI_CMD_ENC_DROPCNT_EN)
module dfi_cmd_encoder
    import dfi_cmd_encoder_pkg::*;
#(
    parameter int ROW_WIDTH      = 15,
    parameter int BANK_WIDTH     = 3,
    parameter int CS_WIDTH       = 1,
    parameter int WAIT_CNT_WIDTH = 10,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [ROW_WIDTH-1:0]   dfi_address,
    input  logic [BANK_WIDTH-1:0]  dfi_bank,
    input  logic [CS_WIDTH-1:0]    dfi_cs_n,
    input  logic                   dfi_ras_n,
    input  logic                   dfi_cas_n,
    input  logic                   dfi_we_n,
    output logic [31:0]            instr_out,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic                   overflow
`ifdef DFI_CMD_ENC_DROPCNT_EN
    ,
    output logic [15:0]            drop_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_MAX = '1;

    logic                      en_q;
    logic                      en_rise;
    logic                      is_cmd;
    cyc_kind_e                 kind;
    logic [WAIT_CNT_WIDTH-1:0] idle_cnt;
    logic [WAIT_CNT_WIDTH-1:0] idle_eff;
    logic [WAIT_CNT_WIDTH-1:0] idle_nxt;
    logic [INSTR_WIDTH-1:0]    ddr_word;
    logic [INSTR_WIDTH-1:0]    wait_word;
    logic [INSTR_WIDTH-1:0]    end_word;
    logic [INSTR_WIDTH-1:0]    w0;
    logic [INSTR_WIDTH-1:0]    w1;
    logic [1:0]                need;
    logic                      accept;
    logic                      drop;
    logic                      put0;
    logic                      put1;
    logic                      pop;
    logic [AW:0]               fifo_count;
    logic [AW:0]               free;

    assign en_rise  = en & ~en_q;
    assign is_cmd   = ~&dfi_cs_n & ({dfi_ras_n, dfi_cas_n, dfi_we_n} != 3'b111);
    assign idle_eff = en_rise ? '0 : idle_cnt;

    always_comb begin
        kind = CYC_OFF;
        if (en)        kind = is_cmd ? CYC_CMD : CYC_IDLE;
        else if (en_q) kind = CYC_CLOSE;
    end

    always_comb begin
        ddr_word = '0;
        ddr_word[31:28]                      = `DDR_INSTR;
        ddr_word[ROW_WIDTH-1:0]              = dfi_address;
        ddr_word[`ROW_OFFSET +: BANK_WIDTH]  = dfi_bank;
        ddr_word[`CS_OFFSET +: CS_WIDTH]     = dfi_cs_n;
        ddr_word[`RAS_OFFSET]                = dfi_ras_n;
        ddr_word[`CAS_OFFSET]                = dfi_cas_n;
        ddr_word[`WE_OFFSET]                 = dfi_we_n;
        wait_word = '0;
        wait_word[31:28]                     = `WAIT;
        wait_word[WAIT_CNT_WIDTH-1:0]        = idle_eff;
        end_word = '0;
        end_word[31:28]                      = `END_ISEQ;
    end

    // Word 0 is always written first, so a pending WAIT goes in slot 0.
    always_comb begin
        need     = 2'd0;
        w0       = wait_word;
        w1       = ddr_word;
        idle_nxt = idle_eff;
        case (kind)
            CYC_CMD: begin
                idle_nxt = '0;
                if (idle_eff != '0) need = 2'd2;
                else begin
                    need = 2'd1;
                    w0   = ddr_word;
                end
            end
            CYC_IDLE: begin
                if (idle_eff == WAIT_MAX) begin
                    need     = 2'd1;
                    idle_nxt = WAIT_CNT_WIDTH'(1);
                end else begin
                    idle_nxt = idle_eff + WAIT_CNT_WIDTH'(1);
                end
            end
            CYC_CLOSE: begin
                idle_nxt = '0;
                w1       = end_word;
                if (idle_eff != '0) need = 2'd2;
                else begin
                    need = 2'd1;
                    w0   = end_word;
                end
            end
            default: idle_nxt = idle_cnt;
        endcase
    end

    assign pop    = instr_valid & instr_ready;
    assign free   = (AW+1)'(FIFO_DEPTH) - fifo_count + (AW+1)'(pop);
    assign accept = (need != 2'd0) && (free >= (AW+1)'(need));
    assign drop   = (need != 2'd0) && !accept;
    assign put0   = accept;
    assign put1   = accept && (need == 2'd2);

    cmd_fifo_2w #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INSTR_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en0   (put0),
        .wr_data0 (w0),
        .wr_en1   (put1),
        .wr_data1 (w1),
        .rd_en    (instr_ready),
        .rd_data  (instr_out),
        .rd_valid (instr_valid),
        .count    (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q     <= 1'b0;
            idle_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            en_q     <= en;
            idle_cnt <= idle_nxt;
            overflow <= drop | (overflow & ~en_rise);
        end
    end

`ifdef DFI_CMD_ENC_DROPCNT_EN
    logic [15:0] drop_base;
    logic [16:0] drop_sum;

    assign drop_base = en_rise ? 16'd0 : drop_cnt;
    assign drop_sum  = {1'b0, drop_base} + (drop ? {15'd0, need} : 17'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt <= 16'd0;
        else        drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
`endif

endmodule

// File: tb/tb_dfi_cmd_encoder.sv
// tb/tb_dfi_cmd_encoder.sv - self-checking bench for dfi_cmd_encoder
module tb_dfi_cmd_encoder;

    localparam int DEPTH = 4;
    localparam int WCW   = 4;
    localparam int MAXW  = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [14:0] dfi_address;
    logic [2:0]  dfi_bank;
    logic [0:0]  dfi_cs_n;
    logic        dfi_ras_n;
    logic        dfi_cas_n;
    logic        dfi_we_n;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        overflow;
`ifdef DFI_CMD_ENC_DROPCNT_EN
    logic [15:0] drop_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dfi_cmd_encoder #(
        .ROW_WIDTH      (15),
        .BANK_WIDTH     (3),
        .CS_WIDTH       (1),
        .WAIT_CNT_WIDTH (WCW),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .dfi_address (dfi_address),
        .dfi_bank    (dfi_bank),
        .dfi_cs_n    (dfi_cs_n),
        .dfi_ras_n   (dfi_ras_n),
        .dfi_cas_n   (dfi_cas_n),
        .dfi_we_n    (dfi_we_n),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .overflow    (overflow)
`ifdef DFI_CMD_ENC_DROPCNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    // Reference model: a queue of pending words plus a popped-word log.
    logic [31:0] q[$];
    logic [31:0] words[$];
    logic [31:0] log_q[$];
    logic [31:0] exp_q[$];
    int          m_idle = 0;
    bit          m_enq  = 0;
    bit          m_ovf  = 0;
    int          m_drop = 0;

    function automatic logic [31:0] ddr_w(input logic cs, input logic r, input logic c,
                                          input logic w, input logic [2:0] b, input logic [14:0] a);
        return {4'h8, 5'b0, r, c, w, 1'b0, cs, b, a};
    endfunction

    function automatic logic [31:0] wait_w(input int n);
        logic [31:0] v;
        v = 32'h4000_0000 | (n & 32'h0000_000F);
        return v;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_idle = 0;
            m_enq  = 0;
            m_ovf  = 0;
            m_drop = 0;
        end else begin
            if (instr_ready && q.size() > 0) log_q.push_back(q.pop_front());
            words.delete();
            if (en && !m_enq) begin
                m_idle = 0;
                m_ovf  = 0;
                m_drop = 0;
            end
            if (en) begin
                if (dfi_cs_n == 1'b0 && {dfi_ras_n, dfi_cas_n, dfi_we_n} != 3'b111) begin
                    if (m_idle > 0) words.push_back(wait_w(m_idle));
                    words.push_back(ddr_w(dfi_cs_n[0], dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_bank, dfi_address));
                    m_idle = 0;
                end else if (m_idle == MAXW) begin
                    words.push_back(wait_w(MAXW));
                    m_idle = 1;
                end else begin
                    m_idle++;
                end
            end else if (m_enq) begin
                if (m_idle > 0) words.push_back(wait_w(m_idle));
                words.push_back(32'h0);
                m_idle = 0;
            end
            if (words.size() > 0) begin
                if (DEPTH - q.size() >= words.size()) begin
                    foreach (words[i]) q.push_back(words[i]);
                end else begin
                    m_ovf  = 1;
                    m_drop = (m_drop + words.size() > 65535) ? 65535 : m_drop + words.size();
                end
            end
            m_enq = en;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, q.size() > 0});
            if (q.size() > 0) chk("instr_out", instr_out, q[0]);
            chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
`ifdef DFI_CMD_ENC_DROPCNT_EN
            chk("drop_cnt", {16'd0, drop_cnt}, m_drop);
`endif
        end
    end

    task automatic step(input logic e, input logic cs, input logic r, input logic c,
                        input logic w, input logic [2:0] b, input logic [14:0] a);
        @(negedge clk);
        en          = e;
        dfi_cs_n    = cs;
        dfi_ras_n   = r;
        dfi_cas_n   = c;
        dfi_we_n    = w;
        dfi_bank    = b;
        dfi_address = a;
    endtask

    task automatic act(input logic [2:0] b, input logic [14:0] row); step(1, 0, 0, 1, 1, b, row); endtask
    task automatic rd(input logic [2:0] b, input logic [14:0] col);  step(1, 0, 1, 0, 1, b, col); endtask
    task automatic pre(input logic [2:0] b);                        step(1, 0, 0, 1, 0, b, 0);   endtask
    task automatic nop();    step(1, 0, 1, 1, 1, 0, 0); endtask
    task automatic desel();  step(1, 1, 1, 1, 1, 0, 0); endtask
    task automatic off(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 1, 1, 1, 0, 0);
    endtask
    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string tname);
        chk({tname, "_len"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < log_q.size()) chk($sformatf("%s_w%0d", tname, i), log_q[i], exp_q[i]);
        log_q.delete();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; instr_ready = 1'b1;
        dfi_cs_n = 1'b1; dfi_ras_n = 1'b1; dfi_cas_n = 1'b1; dfi_we_n = 1'b1;
        dfi_bank = '0; dfi_address = '0;
        wait_edge();
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_out", instr_out, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        off(2);
        rst_n = 1'b1;
        off(2);
        log_q.delete();

        // T2 back-to-back
        act(1, 15'h1234); rd(1, 15'h10); off(5);
        exp_q = '{32'h8030_9234, 32'h8050_8010, 32'h0000_0000};
        check_log("t2");

        // T3 gap of five NOPs
        act(1, 15'h1234);
        for (int i = 0; i < 5; i++) nop();
        pre(1); off(5);
        exp_q = '{32'h8030_9234, 32'h4000_0005, 32'h8020_8000, 32'h0000_0000};
        check_log("t3");

        // T4 saturation of the 4-bit counter
        act(1, 15'h1234);
        for (int i = 0; i < 20; i++) desel();
        off(5);
        exp_q = '{32'h8030_9234, 32'h4000_000F, 32'h4000_0005, 32'h0000_0000};
        check_log("t4");

        // T1 reset mid-stream discards held words
        instr_ready = 1'b0;
        act(3, 15'h0042); nop(); nop();
        @(negedge clk);
        rst_n = 1'b0;
        wait_edge();
        chk("t1_valid", {31'd0, instr_valid}, 32'd0);
        chk("t1_ovf", {31'd0, overflow}, 32'd0);
        off(1);
        rst_n = 1'b1; instr_ready = 1'b1; log_q.delete();
        rd(2, 15'h20); off(5);
        exp_q = '{32'h8051_0020, 32'h0000_0000};
        check_log("t1");

        // T5 backpressure: six commands into four entries
        rd(0, 15'h1); instr_ready = 1'b0;
        rd(0, 15'h2); rd(0, 15'h3); rd(0, 15'h4); rd(0, 15'h5); rd(0, 15'h6);
        wait_edge();
        chk("t5_ovf", {31'd0, overflow}, 32'd1);
        chk("t5_valid", {31'd0, instr_valid}, 32'd1);
`ifdef DFI_CMD_ENC_DROPCNT_EN
        chk("t5_drop", {16'd0, drop_cnt}, 32'd2);
`endif
        log_q.delete();
        off(1); instr_ready = 1'b1;
        off(6);
        exp_q = '{32'h8050_0001, 32'h8050_0002, 32'h8050_0003, 32'h8050_0004, 32'h0000_0000};
        check_log("t5");

        // T5b two-word cycle with one free entry writes nothing
        rd(0, 15'h11); instr_ready = 1'b0;
        rd(0, 15'h12); rd(0, 15'h13); nop(); nop(); rd(0, 15'h14);
        wait_edge();
        chk("t5b_ovf", {31'd0, overflow}, 32'd1);
`ifdef DFI_CMD_ENC_DROPCNT_EN
        chk("t5b_drop", {16'd0, drop_cnt}, 32'd2);
`endif
        off(2);
        log_q.delete();
        off(1); instr_ready = 1'b1;
        off(6);
        exp_q = '{32'h8050_0011, 32'h8050_0012, 32'h8050_0013, 32'h0000_0000};
        check_log("t5b");

        // T6 push into a full FIFO alongside a pop
        rd(0, 15'h21); instr_ready = 1'b0;
        rd(0, 15'h22); rd(0, 15'h23); rd(0, 15'h24);
        rd(0, 15'h25); instr_ready = 1'b1;
        wait_edge();
        chk("t6_ovf", {31'd0, overflow}, 32'd0);
        off(7);
        exp_q = '{32'h8050_0021, 32'h8050_0022, 32'h8050_0023, 32'h8050_0024,
                  32'h8050_0025, 32'h0000_0000};
        check_log("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
